// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared core-wide constants and types for the front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Architectural address / PC width.
  localparam int unsigned RV_XLEN = 32;

  // Instruction word width.
  localparam int unsigned RV_ILEN = 32;

  // Address of the first instruction fetched after reset.
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  // One instruction word.
  typedef logic [RV_ILEN-1:0] instr_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch PC generator plus DEPTH-entry in-order
//                queue between instruction memory and decode. Handles
//                redirects by flushing and discarding stale responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned         XLEN     = RV_XLEN,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [XLEN-1:0]     RESET_PC = XLEN'(RV_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rstn,
  // instruction memory request channel
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  // instruction memory response channel (in order, no backpressure)
  input  logic                   imem_rsp_valid,
  input  logic [RV_ILEN-1:0]     imem_rsp_data,
  // redirect from execute
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  // decode interface
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [XLEN-1:0]        id_pc,
  output logic [RV_ILEN-1:0]     id_instr
);

  // Pointer, occupancy and discard counter widths. The discard counter is
  // wider than the occupancy because back-to-back redirects against a slow
  // memory can stack several queue-loads of stale responses.
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = PW + 4;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Architectural state
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [PW-1:0]      fill_q, fill_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      pend_q, pend_d;
  logic [DW-1:0]      disc_q, disc_d;
  logic [DEPTH-1:0]   filled_q, filled_d;
  logic [XLEN-1:0]    pc_mem_q    [DEPTH];
  logic [XLEN-1:0]    pc_mem_d    [DEPTH];
  instr_t             instr_mem_q [DEPTH];
  instr_t             instr_mem_d [DEPTH];

  // Handshake qualifiers
  logic               req_fire;
  logic               pop_fire;
  logic               fill_fire;
  logic [DW-1:0]      outstanding;

  // Requests stop while flushing, when the queue is full, or while in reset.
  assign imem_req_valid = rstn && !redirect_valid && (count_q < FULL_CNT);
  assign imem_req_addr  = pc_q;

  assign id_valid = (count_q != '0) && filled_q[head_q];
  assign id_pc    = pc_mem_q[head_q];
  assign id_instr = instr_mem_q[head_q];

  assign req_fire    = imem_req_valid && imem_req_ready;
  assign pop_fire    = id_valid && id_ready;
  // A response only lands in the queue when nothing stale is still due.
  assign fill_fire   = imem_rsp_valid && (disc_q == '0) && (pend_q != '0);
  // Requests still in flight at memory, whether stale or live.
  assign outstanding = disc_q + DW'(pend_q);

  // Next-state computation: redirect overrides pop, allocate and fill.
  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    count_d     = count_q;
    pend_d      = pend_q;
    disc_d      = disc_q;
    filled_d    = filled_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (redirect_valid) begin
      pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      count_d  = '0;
      pend_d   = '0;
      filled_d = '0;
      // Everything still in flight becomes stale; a response arriving now
      // retires one of them immediately.
      if (imem_rsp_valid && (outstanding != '0)) begin
        disc_d = outstanding - DW'(1);
      end else begin
        disc_d = outstanding;
      end
    end else begin
      if (req_fire) begin
        pc_mem_d[tail_q] = pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
        pc_d             = pc_q + XLEN'(4);
      end

      if (imem_rsp_valid && (disc_q != '0)) begin
        disc_d = disc_q - DW'(1);
      end else if (fill_fire) begin
        instr_mem_d[fill_q] = imem_rsp_data;
        filled_d[fill_q]    = 1'b1;
        fill_d              = fill_q + PW'(1);
      end

      if (pop_fire) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end

      count_d = count_q + CW'(req_fire) - CW'(pop_fire);
      pend_d  = pend_q + CW'(req_fire) - CW'(fill_fire);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      disc_q      <= '0;
      filled_q    <= '0;
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      disc_q      <= disc_d;
      filled_q    <= filled_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

endmodule : fetch_queue
`default_nettype wire
